// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 block loader and its core sequencer.
package sha256_pkg;

  localparam int MSG_WORDS  = 16;
  localparam int HASH_WORDS = 8;
  localparam int WORD_W     = 32;

  localparam int MSG_IDX_W  = $clog2(MSG_WORDS);
  localparam int HASH_IDX_W = $clog2(HASH_WORDS);
  localparam int MSG_W      = MSG_WORDS * WORD_W;
  localparam int HASH_W     = HASH_WORDS * WORD_W;

  // Sticky error flag positions
  localparam int ERR_W       = 2;
  localparam int ERR_PROTO   = 0;  // start on incomplete block, or write while busy
  localparam int ERR_TIMEOUT = 1;  // core never raised ready

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CORE_RST,
    ST_WAIT_RDY,
    ST_DONE
  } state_e;

  // One-hot mask bit for a message word index
  function automatic logic [MSG_WORDS-1:0] word_bit(input logic [MSG_IDX_W-1:0] idx);
    word_bit      = '0;
    word_bit[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sha256_block_loader_if.sv
// Software-facing register bus of the SHA-256 block loader.
interface sha256_block_loader_if;
  import sha256_pkg::*;

  logic                  wr_en;
  logic [MSG_IDX_W-1:0]  wr_idx;
  logic [WORD_W-1:0]     wr_data;
  logic                  start;
  logic [HASH_IDX_W-1:0] rd_idx;
  logic [WORD_W-1:0]     rd_data;
  logic                  busy;
  logic                  done;
  logic [ERR_W-1:0]      err;

  modport master (
    output wr_en, wr_idx, wr_data, start, rd_idx,
    input  rd_data, busy, done, err
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, start, rd_idx,
    output rd_data, busy, done, err
  );

endinterface

// File: rtl/sha256_core_seq.sv
// Drives the hash core's reset/ready handshake for one run, with a ready timeout.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | no run yet, or last run timed out; core held in reset
//   ST_CORE_RST  | core_reset held high for RST_CYCLES cycles; ready ignored
//   ST_WAIT_RDY  | core released; waiting for ready, bounded by TIMEOUT
//   ST_DONE      | last run captured a digest; core held in reset
module sha256_core_seq
  import sha256_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,       // accepted start from the loader
  input  logic core_ready_i,
  output logic core_reset_o,
  output logic done_o,        // one-cycle strobe: capture core_hash this edge
  output logic timeout_o      // one-cycle strobe: run aborted this edge
);

  // The counter also times the reset phase, so it must hold at least RST_CYCLES-1.
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W = (TMO_W > 4) ? TMO_W : 4;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_reset_q, core_reset_d;

  // Next-state, counter and handshake strobes
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    core_reset_d = core_reset_q;
    done_o       = 1'b0;
    timeout_o    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d      = ST_CORE_RST;
          cnt_d        = '0;
          core_reset_d = 1'b1;
        end
      end
      ST_CORE_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d      = ST_WAIT_RDY;
          cnt_d        = '0;
          core_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_RDY: begin
        // The first cycle with core_reset low is skipped: the core has not
        // yet seen its reset released, so ready may still be stale.
        if ((cnt_q != '0) && core_ready_i) begin
          done_o       = 1'b1;
          state_d      = ST_DONE;
          core_reset_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          timeout_o    = 1'b1;
          state_d      = ST_IDLE;
          core_reset_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        core_reset_d = 1'b1;
      end
    endcase
  end

  // State registers; reset re-holds the core in reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign core_reset_o = core_reset_q;

endmodule

// File: rtl/sha256_block_loader.sv
// Bus front end for the SHA-256 core: assembles a 512-bit block from word
// writes, launches a hash run and holds the resulting digest for readback.
module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                clk,
  input  logic                reset,
  sha256_block_loader_if.slave bus,
  output logic [MSG_W-1:0]    core_message,
  output logic                core_reset,
  input  logic                core_ready,
  input  logic [HASH_W-1:0]   core_hash
);

  // Word 0 sits in the top slot so the packed block is MSB-first.
  localparam logic [MSG_IDX_W-1:0]  LAST_MSG  = MSG_IDX_W'(MSG_WORDS - 1);
  localparam logic [HASH_IDX_W-1:0] LAST_HASH = HASH_IDX_W'(HASH_WORDS - 1);

  logic [MSG_WORDS-1:0][WORD_W-1:0]  msg_q, msg_d;
  logic [HASH_WORDS-1:0][WORD_W-1:0] digest_q, digest_d;
  logic [MSG_WORDS-1:0]              mask_q, mask_d;
  logic                              busy_q, busy_d;
  logic                              done_q, done_d;
  logic [ERR_W-1:0]                  err_q, err_d;

  logic [MSG_WORDS-1:0] wr_mask;
  logic                 seq_start;
  logic                 seq_done;
  logic                 seq_timeout;

  // Word writes, start qualification and run completion bookkeeping
  always_comb begin
    msg_d     = msg_q;
    digest_d  = digest_q;
    mask_d    = mask_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    seq_start = 1'b0;
    wr_mask   = bus.wr_en ? word_bit(bus.wr_idx) : '0;

    if (busy_q) begin
      // The block under hash must not change; start is silently dropped.
      if (bus.wr_en) begin
        err_d[ERR_PROTO] = 1'b1;
      end
      if (seq_done) begin
        digest_d = core_hash;
        mask_d   = '0;
        busy_d   = 1'b0;
        done_d   = 1'b1;
      end
      if (seq_timeout) begin
        err_d[ERR_TIMEOUT] = 1'b1;
        busy_d             = 1'b0;
        done_d             = 1'b0;
      end
    end else begin
      if (bus.wr_en) begin
        msg_d[LAST_MSG - bus.wr_idx] = bus.wr_data;
        mask_d                       = mask_q | wr_mask;
      end
      // A write in the same cycle as start counts toward completeness.
      if (bus.start) begin
        if ((mask_q | wr_mask) == {MSG_WORDS{1'b1}}) begin
          seq_start = 1'b1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = '0;
        end else begin
          err_d[ERR_PROTO] = 1'b1;
        end
      end
    end
  end

  // Loader registers
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_q    <= '0;
      digest_q <= '0;
      mask_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      msg_q    <= msg_d;
      digest_q <= digest_d;
      mask_q   <= mask_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  sha256_core_seq #(
    .RST_CYCLES (RST_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) u_core_seq (
    .clk          (clk),
    .reset        (reset),
    .start_i      (seq_start),
    .core_ready_i (core_ready),
    .core_reset_o (core_reset),
    .done_o       (seq_done),
    .timeout_o    (seq_timeout)
  );

  assign core_message = msg_q;
  assign bus.rd_data  = digest_q[LAST_HASH - bus.rd_idx];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_sha256_block_loader.sv
// Directed bench for sha256_block_loader with a hand-driven core model.
module tb_sha256_block_loader;
  import sha256_pkg::*;

  localparam int RST_CYC = 2;
  localparam int TMO     = 8;

  localparam logic [511:0] ABC_MSG    = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_HASH   = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                         32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] H2_HASH    = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                         32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  localparam logic [255:0] STALE_HASH = {8{32'h5a5a5a5a}};

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] exp;
  } rd_vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] core_message;
  logic         core_reset;
  logic         core_ready;
  logic [255:0] core_hash;

  int n_checks = 0;
  int n_fail   = 0;
  rd_vec_t rd_tab[8];

  sha256_block_loader_if bus();

  sha256_block_loader #(
    .RST_CYCLES (RST_CYC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .core_message (core_message),
    .core_reset   (core_reset),
    .core_ready   (core_ready),
    .core_hash    (core_hash)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] abc_word(input int i);
    if (i == 0)  return 32'h61626380;
    if (i == 15) return 32'h00000018;
    return 32'h0;
  endfunction

  task automatic write_word(input logic [3:0] idx, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = idx;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic load_abc(input int n);
    for (int i = 0; i < n; i++) write_word(4'(i), abc_word(i));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Core model: wait for reset release, drop any stale ready, then present h.
  task automatic finish_run(input logic [255:0] h);
    int k;
    k = 0;
    while (core_reset === 1'b1 && k < 40) begin tick(); k++; end
    core_ready = 1'b0;
    chk("core_reset_release", 512'(core_reset), 512'(1'b0));
    tick();
    tick();
    core_hash  = h;
    core_ready = 1'b1;
    k = 0;
    while (bus.done !== 1'b1 && k < 40) begin tick(); k++; end
    core_ready = 1'b0;
    chk("run_done", 512'(bus.done), 512'(1'b1));
    chk("run_busy_clear", 512'(bus.busy), 512'(1'b0));
    chk("run_core_reset_reheld", 512'(core_reset), 512'(1'b1));
  endtask

  task automatic check_digest(input string tag);
    for (int i = 0; i < 8; i++) begin
      bus.rd_idx = rd_tab[i].idx;
      #1;
      chk($sformatf("%s_rd%0d", tag, i), 512'(bus.rd_data), 512'(rd_tab[i].exp));
    end
  endtask

  task automatic check_reset_values(input string tag);
    bus.rd_idx = 3'd0;
    #1;
    chk({tag, "_core_reset"}, 512'(core_reset), 512'(1'b1));
    chk({tag, "_busy"}, 512'(bus.busy), 512'(1'b0));
    chk({tag, "_done"}, 512'(bus.done), 512'(1'b0));
    chk({tag, "_err"}, 512'(bus.err), 512'(2'b00));
    chk({tag, "_rd_data"}, 512'(bus.rd_data), 512'(32'h0));
    chk({tag, "_message"}, core_message, 512'(0));
  endtask

  initial begin
    int k;
    rd_tab[0] = '{3'd0, 32'hba7816bf};
    rd_tab[1] = '{3'd1, 32'h8f01cfea};
    rd_tab[2] = '{3'd2, 32'h414140de};
    rd_tab[3] = '{3'd3, 32'h5dae2223};
    rd_tab[4] = '{3'd4, 32'hb00361a3};
    rd_tab[5] = '{3'd5, 32'h96177a9c};
    rd_tab[6] = '{3'd6, 32'hb410ff61};
    rd_tab[7] = '{3'd7, 32'hf20015ad};

    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_idx  = 4'd0;
    bus.wr_data = 32'h0;
    bus.start   = 1'b0;
    bus.rd_idx  = 3'd0;
    core_ready  = 1'b0;
    core_hash   = '0;

    // Reset values
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;

    // Start with word 15 missing
    load_abc(15);
    pulse_start();
    chk("incomplete_busy", 512'(bus.busy), 512'(1'b0));
    chk("incomplete_err", 512'(bus.err), 512'(2'b01));
    chk("incomplete_done", 512'(bus.done), 512'(1'b0));
    tick();
    chk("incomplete_core_reset", 512'(core_reset), 512'(1'b1));
    chk("incomplete_still_idle", 512'(bus.busy), 512'(1'b0));

    // Last word written in the same cycle as start completes the block
    bus.wr_en   = 1'b1;
    bus.wr_idx  = 4'd15;
    bus.wr_data = 32'h00000018;
    bus.start   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
    bus.start   = 1'b0;
    chk("abc_busy", 512'(bus.busy), 512'(1'b1));
    chk("abc_err_cleared", 512'(bus.err), 512'(2'b00));
    chk("abc_message", core_message, ABC_MSG);
    k = 0;
    while (core_reset === 1'b1 && k < 20) begin tick(); k++; end
    chk("abc_core_reset_len", 512'(k), 512'(RST_CYC));
    finish_run(ABC_HASH);
    chk("abc_err", 512'(bus.err), 512'(2'b00));
    check_digest("abc");

    // Write while busy is dropped and flagged
    load_abc(16);
    pulse_start();
    chk("busywr_done_cleared", 512'(bus.done), 512'(1'b0));
    chk("busywr_busy", 512'(bus.busy), 512'(1'b1));
    write_word(4'd3, 32'hDEADBEEF);
    chk("busywr_err", 512'(bus.err), 512'(2'b01));
    chk("busywr_message", core_message, ABC_MSG);
    finish_run(H2_HASH);
    bus.rd_idx = 3'd3;
    #1;
    chk("busywr_rd3", 512'(bus.rd_data), 512'(32'h44444444));
    chk("busywr_err_sticky", 512'(bus.err), 512'(2'b01));

    // Stale ready during core reset must not be captured
    load_abc(16);
    core_hash  = STALE_HASH;
    core_ready = 1'b1;
    pulse_start();
    tick();
    chk("stale_done_low", 512'(bus.done), 512'(1'b0));
    chk("stale_busy", 512'(bus.busy), 512'(1'b1));
    finish_run(ABC_HASH);
    check_digest("stale");

    // Core never becomes ready
    load_abc(16);
    pulse_start();
    k = 0;
    while (bus.err[1] !== 1'b1 && k < 40) begin tick(); k++; end
    chk("tmo_cycles", 512'(k), 512'(RST_CYC + 9));
    chk("tmo_err", 512'(bus.err), 512'(2'b10));
    chk("tmo_busy", 512'(bus.busy), 512'(1'b0));
    chk("tmo_done", 512'(bus.done), 512'(1'b0));
    chk("tmo_core_reset", 512'(core_reset), 512'(1'b1));
    bus.rd_idx = 3'd0;
    #1;
    chk("tmo_digest_kept", 512'(bus.rd_data), 512'(32'hba7816bf));

    // Reset mid-run, then a clean run
    load_abc(16);
    pulse_start();
    k = 0;
    while (core_reset === 1'b1 && k < 20) begin tick(); k++; end
    chk("midrst_in_wait", 512'(core_reset), 512'(1'b0));
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_values("midrst");
    reset = 1'b0;
    load_abc(16);
    pulse_start();
    finish_run(ABC_HASH);
    chk("midrst_err", 512'(bus.err), 512'(2'b00));
    check_digest("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_block_loader.md
Name: sha256_block_loader

Overview:
- Bus-side front end for the SHA-256 core. Sits between the AXI peripheral address decode and the `overall` hash core.
- Collects sixteen 32-bit word writes into one 512-bit message block and sequences the core's reset/ready handshake.
- Captures the 256-bit digest and exposes it as eight readable 32-bit words, plus status and error flags for software polling.

Parameters:
- RST_CYCLES, 2, cycles core_reset is held high at the start of a hash run (1..15).
- TIMEOUT, 1024, max cycles to wait for core_ready after reset release before aborting.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  one-cycle message word write strobe.
- wr_idx  in  4  message word index 0..15.
- wr_data  in  32  message word.
- start  in  1  one-cycle command to hash the loaded block.
- rd_idx  in  3  digest word select 0..7.
- rd_data  out  32  selected digest word, combinational from the digest register.
- busy  out  1  hash run in progress.
- done  out  1  digest valid.
- err  out  2  sticky flags: [0] start with incomplete block or write while busy; [1] timeout.
- core_message  out  512  block to the core; bit 511 = MSB of word 0.
- core_reset  out  1  core reset, active high.
- core_ready  in  1  core done flag.
- core_hash  in  256  core digest.

Behaviour:
- Reset values:
  - state=IDLE; message, digest and word mask = 0.
  - core_reset=1, busy=0, done=0, err=0, rd_data=0.
- Word mapping:
  - word i occupies core_message[511-32i -: 32].
  - digest word j = digest[255-32j -: 32].
- States: IDLE, CORE_RST, WAIT_RDY, DONE.
- IDLE/DONE:
  - wr_en writes the word and sets mask[wr_idx]. Rewriting a word overwrites it; the mask stays set.
  - start with mask==16'hFFFF → CORE_RST: done←0, busy←1, err←0, counter←0.
  - start with an incomplete mask → no state change; err[0]←1.
  - wr_en and start in the same cycle: the write lands first and counts toward the mask.
- CORE_RST:
  - core_reset=1 for exactly RST_CYCLES cycles.
  - Then core_reset←0 → WAIT_RDY with counter←0.
  - core_ready is ignored in this state, because it may be stale high.
- WAIT_RDY:
  - core_ready is sampled starting one cycle after core_reset falls.
  - On core_ready=1: digest←core_hash, mask←0, busy←0, done←1, core_reset←1 → DONE.
  - If the counter reaches TIMEOUT first: err[1]←1, busy←0, done←0, core_reset←1 → IDLE; the digest is unchanged.
- Writes while busy: ignored, message untouched, err[0]←1.
- start while busy: ignored, with no error flag.
- core_message is stable for the whole run.
- done stays high until the next accepted start or reset. rd_data is valid whenever done=1.
- Reset in any state: immediate return to reset values, including mid-run; the core is re-held in reset.
- Counter: $clog2(TIMEOUT+1) bits, saturating, never wraps.

Decomposition:
- Shared package sha256_pkg:
  - state enum.
  - constants MSG_WORDS=16, HASH_WORDS=8, WORD_W=32.
  - err bit positions.
- Sub-module sha256_core_seq: owns the CORE_RST/WAIT_RDY sequencing, timeout counter and core_reset generation. It gives start/done/timeout pulses to the loader. Word assembly and the digest register stay in the top.

Test Plan:
- Load "abc" block (word0=32'h61626380, words1–14=0, word15=32'h00000018), start, model core → rd_idx 0..7 give ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done=1, busy=0, err=0.
- Write words 0–14 only, start → stays IDLE, busy=0, err=2'b01, core_reset stays 1.
- Core held at ready=0, TIMEOUT=8 → err=2'b10, busy=0, done=0 after RST_CYCLES+9 cycles; state IDLE.
- core_ready high during CORE_RST (stale) → not captured; capture happens only when ready is asserted after reset release.
- Write word 3=32'hDEADBEEF while busy → core_message unchanged, err[0]=1, run completes normally.
- Assert reset two cycles into WAIT_RDY → all outputs back to reset values; the next full load + start hashes correctly.
